// File: rtl/router_pkg.sv
// Shared types and helpers for the router packet source: FSM state encoding,
// the illegal destination code and the header byte packing.
package router_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_HDR,
        ST_PLD,
        ST_PAR,
        ST_ERRW,
        ST_REPORT,
        ST_GAP
    } src_state_t;

    localparam logic [1:0] ADDR_ILLEGAL = 2'b11;

    function automatic logic [7:0] hdr(input logic [5:0] len, input logic [1:0] addr);
        return {len, addr};
    endfunction

endpackage

// File: rtl/router_src_buf.sv
// Payload byte FIFO: DEPTH x 8, pointers wrap modulo DEPTH, with head and
// one-ahead peek so the framer can register the following byte on a pop.
module router_src_buf #(
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [7:0]    wdata_i,
    output logic [7:0]    head_o,
    output logic [7:0]    next_o,
    output logic [AW:0]   count_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          wr, rd;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign wr      = push_i && !full_o;
    assign rd      = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign next_o  = mem_q[ptr_inc(rd_ptr_q)];

    always_ff @(posedge clock) begin
        if (wr) mem_q[wr_ptr_q] <= wdata_i;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (rd) rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({wr, rd})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/router_pkt_source.sv
// Packet framer for the 1x3 router input: buffers a full payload, then sends
// header, payload and XOR parity, watches router error and reports status.
module router_pkt_source
    import router_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int ERR_WIN = 4,
    parameter int GAP     = 2
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_addr,
    input  logic [5:0] cmd_len,
    input  logic       pl_valid,
    output logic       pl_ready,
    input  logic [7:0] pl_data,
    input  logic       busy,
    input  logic       error,
    output logic       pkt_valid,
    output logic [7:0] data_in,
    output logic       done,
    output logic       done_err,
    output logic       bad_cmd
);

    localparam int CNTW = $clog2(DEPTH) + 1;
    localparam int CW   = 8;

    src_state_t      state_q;
    logic [1:0]      addr_q;
    logic [5:0]      len_q, rem_q;
    logic [7:0]      par_q, data_q;
    logic [CW-1:0]   cnt_q;
    logic            err_q;
    logic            cmd_ready_q, pkt_valid_q, done_q, done_err_q, bad_cmd_q;

    logic [7:0]      head, next;
    logic [CNTW-1:0] count;
    logic            full, empty, pop;

    assign pop = (state_q == ST_PLD) && !busy && !empty;

    router_src_buf #(.DEPTH(DEPTH)) u_buf (
        .clock   (clock),
        .resetn  (resetn),
        .push_i  (pl_valid),
        .pop_i   (pop),
        .wdata_i (pl_data),
        .head_o  (head),
        .next_o  (next),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    assign pl_ready  = !full;
    assign cmd_ready = cmd_ready_q;
    assign pkt_valid = pkt_valid_q;
    assign data_in   = data_q;
    assign done      = done_q;
    assign done_err  = done_err_q;
    assign bad_cmd   = bad_cmd_q;

    // Outputs are loaded on the transition so they always match state_q.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            rem_q       <= '0;
            par_q       <= '0;
            data_q      <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
            pkt_valid_q <= 1'b0;
            done_q      <= 1'b0;
            done_err_q  <= 1'b0;
            bad_cmd_q   <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            done_err_q <= 1'b0;
            bad_cmd_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        addr_q      <= cmd_addr;
                        len_q       <= cmd_len;
                        if (cmd_addr == ADDR_ILLEGAL || cmd_len == '0) begin
                            state_q   <= ST_REPORT;
                            done_q    <= 1'b1;
                            bad_cmd_q <= 1'b1;
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end
                end
                // Whole payload must be resident so pkt_valid never gaps.
                ST_WAIT: begin
                    if (count >= CNTW'(len_q)) begin
                        state_q     <= ST_HDR;
                        pkt_valid_q <= 1'b1;
                        data_q      <= hdr(len_q, addr_q);
                        par_q       <= hdr(len_q, addr_q);
                        rem_q       <= len_q;
                    end
                end
                ST_HDR: begin
                    if (!busy) begin
                        state_q <= ST_PLD;
                        data_q  <= head;
                    end
                end
                ST_PLD: begin
                    if (!busy) begin
                        par_q <= par_q ^ data_q;
                        rem_q <= rem_q - 1'b1;
                        if (rem_q == 6'd1) begin
                            state_q     <= ST_PAR;
                            pkt_valid_q <= 1'b0;
                            data_q      <= par_q ^ data_q;
                        end else begin
                            data_q <= next;
                        end
                    end
                end
                ST_PAR: begin
                    if (!busy) begin
                        state_q <= ST_ERRW;
                        data_q  <= '0;
                        cnt_q   <= '0;
                        err_q   <= 1'b0;
                    end
                end
                ST_ERRW: begin
                    err_q <= err_q | error;
                    if (cnt_q == CW'(ERR_WIN - 1)) begin
                        state_q    <= ST_REPORT;
                        done_q     <= 1'b1;
                        done_err_q <= err_q | error;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_REPORT: begin
                    cnt_q <= '0;
                    if (GAP == 0) begin
                        state_q     <= ST_IDLE;
                        cmd_ready_q <= 1'b1;
                    end else begin
                        state_q <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (cnt_q == CW'(GAP - 1)) begin
                        state_q     <= ST_IDLE;
                        cmd_ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
